// File: rtl/noc_channel_arbiter_pkg.sv
// Shared types and defaults for the NoC channel arbiter and its round-robin helper.
// Default flit width and credit depth live here so the router can reuse them.
package noc_channel_arbiter_pkg;

  localparam int unsigned NocDataWidth   = 32;
  localparam int unsigned NocCreditDepth = 4;

  typedef enum logic {
    StIdle,
    StLocked
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at index >= ptr, wrapping.
// Shared with the router switch allocator.
module noc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    grant_idx,
  output logic               grant_valid
);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IdxW'((32'(ptr) + off) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_channel_arbiter.sv
// Wormhole, packet-locked round-robin arbiter sharing one credit-flow-controlled NoC channel.
// The flit path is purely combinational; only ownership, pointer, credits and errors are stored.
module noc_channel_arbiter
  import noc_channel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = NocDataWidth,
  parameter int unsigned CREDIT_DEPTH = NocCreditDepth
) (
  input  logic                      noc_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_is_header,
  input  logic [NUM_REQ-1:0]        req_is_tail,
  output logic [NUM_REQ-1:0]        req_VCready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_flit,
  output logic                      out_is_header,
  output logic                      out_is_tail,
  input  logic                      out_credit_ret,
  output logic                      err_protocol,
  output logic                      err_credit_ovf
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CREDIT_DEPTH);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] credit_q, credit_d;
  logic            err_protocol_q, err_protocol_d;
  logic            err_credit_ovf_q, err_credit_ovf_d;

  logic [NUM_REQ-1:0] arb_grant, owner_oh, sel_oh, foreign_mask;
  logic [IdxW-1:0]    arb_idx, sel;
  logic               arb_valid, sel_ok, has_credit, xfer;

  noc_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req        (req_valid & req_is_header),
    .ptr        (rr_ptr_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  always_comb begin
    has_credit = (credit_q != '0);
    owner_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    if (state_q == StLocked) begin
      sel          = owner_q;
      sel_oh       = owner_oh;
      sel_ok       = req_valid[owner_q] & ~req_is_header[owner_q];
      foreign_mask = ~owner_oh;
    end else begin
      sel          = arb_idx;
      sel_oh       = arb_grant;
      sel_ok       = arb_valid;
      foreign_mask = '1;
    end
    // Credit gating on valid is what keeps the counter from underflowing.
    out_valid     = sel_ok & has_credit & ~rst;
    xfer          = out_valid & out_ready;
    req_ready     = xfer ? sel_oh : '0;
    out_flit      = req_flit[sel*DATA_W +: DATA_W];
    out_is_header = req_is_header[sel];
    out_is_tail   = req_is_tail[sel];
    req_VCready   = {NUM_REQ{has_credit}};
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    credit_d         = credit_q;
    err_protocol_d   = err_protocol_q;
    err_credit_ovf_d = err_credit_ovf_q;

    if (xfer) begin
      if (state_q == StIdle) begin
        rr_ptr_d = IdxW'(rr_next(32'(sel), NUM_REQ));
        if (!out_is_tail) begin
          state_d = StLocked;
          owner_d = sel;
        end
      end else if (out_is_tail) begin
        state_d = StIdle;
      end
    end

    if (|(req_valid & ~req_is_header & foreign_mask) ||
        (state_q == StLocked && req_valid[owner_q] && req_is_header[owner_q])) begin
      err_protocol_d = 1'b1;
    end

    case ({xfer, out_credit_ret})
      2'b10:   credit_d = credit_q - CntW'(1);
      2'b01: begin
        if (credit_q == CntMax) err_credit_ovf_d = 1'b1;
        else                    credit_d = credit_q + CntW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (rst) begin
      state_q          <= StIdle;
      owner_q          <= '0;
      rr_ptr_q         <= '0;
      credit_q         <= CntMax;
      err_protocol_q   <= 1'b0;
      err_credit_ovf_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      rr_ptr_q         <= rr_ptr_d;
      credit_q         <= credit_d;
      err_protocol_q   <= err_protocol_d;
      err_credit_ovf_q <= err_credit_ovf_d;
    end
  end

  assign err_protocol   = err_protocol_q;
  assign err_credit_ovf = err_credit_ovf_q;

endmodule

// File: tb/tb_noc_channel_arbiter.sv
// Directed bench for noc_channel_arbiter: inputs change 1ns after the rising edge and
// combinational outputs are sampled 1ns later, well before the next edge.
module tb_noc_channel_arbiter;
  import noc_channel_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CD = 4;

  logic           noc_clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_ready, req_is_header, req_is_tail, req_VCready;
  logic [N*W-1:0] req_flit;
  logic           out_valid, out_ready, out_is_header, out_is_tail, out_credit_ret;
  logic [W-1:0]   out_flit;
  logic           err_protocol, err_credit_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  noc_channel_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .CREDIT_DEPTH(CD)
  ) dut (
    .noc_clk       (noc_clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_flit      (req_flit),
    .req_is_header (req_is_header),
    .req_is_tail   (req_is_tail),
    .req_VCready   (req_VCready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .out_credit_ret(out_credit_ret),
    .err_protocol  (err_protocol),
    .err_credit_ovf(err_credit_ovf)
  );

  always #5 noc_clk = ~noc_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic put(input int r, input bit v, input bit h, input bit t, input logic [W-1:0] f);
    req_valid[r]      = v;
    req_is_header[r]  = h;
    req_is_tail[r]    = t;
    req_flit[r*W +: W] = f;
  endtask

  task automatic idle_all();
    req_valid     = '0;
    req_is_header = '0;
    req_is_tail   = '0;
    req_flit      = '0;
  endtask

  task automatic do_reset();
    idle_all();
    out_credit_ret = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expects valid=1 with the given ready vector and flit this cycle.
  task automatic expect_xfer(input string tag, input logic [N-1:0] rdy, input logic [W-1:0] f);
    #1;
    check(tag, {out_valid, req_ready, out_flit}, {1'b1, rdy, f});
  endtask

  task automatic expect_stall(input string tag);
    #1;
    check(tag, {out_valid, req_ready}, '0);
  endtask

  initial begin
    idle_all();
    out_ready      = 1'b1;
    out_credit_ret = 1'b0;

    // 1: reset state, then a 3-flit packet from req0
    tick();
    put(0, 1, 1, 0, 16'hA0);
    expect_stall("t1_rst_gate");
    tick();
    rst = 1'b0;
    #1;
    check("t1_rst_state", dut.state_q, StIdle);
    check("t1_rst_credit", dut.credit_q, 4);
    check("t1_rst_vcready", req_VCready, 4'hF);
    check("t1_rst_err", {err_protocol, err_credit_ovf}, 0);
    expect_xfer("t1_head", 4'b0001, 16'hA0);
    tick();
    put(0, 1, 0, 0, 16'hA1);
    expect_xfer("t1_body", 4'b0001, 16'hA1);
    tick();
    put(0, 1, 0, 1, 16'hA2);
    expect_xfer("t1_tail", 4'b0001, 16'hA2);
    check("t1_tail_flag", out_is_tail, 1);
    tick();
    idle_all();
    #1;
    check("t1_credit", dut.credit_q, 1);
    check("t1_idle", dut.state_q, StIdle);
    check("t1_vcready", req_VCready, 4'hF);
    out_credit_ret = 1'b1;
    tick();
    tick();
    tick();
    out_credit_ret = 1'b0;
    #1;
    check("t1_refill", dut.credit_q, 4);

    // 2: all four requesters, 2-flit packets, served 0,1,2,3; credit returned every cycle
    do_reset();
    for (int i = 0; i < N; i++) put(i, 1, 1, 0, 16'(16'h10 + i));
    out_credit_ret = 1'b1;
    for (int k = 0; k < N; k++) begin
      expect_xfer($sformatf("t2_head%0d", k), 4'(1 << k), 16'(16'h10 + k));
      tick();
      put(k, 1, 0, 1, 16'(16'h20 + k));
      expect_xfer($sformatf("t2_tail%0d", k), 4'(1 << k), 16'(16'h20 + k));
      tick();
      put(k, 0, 0, 0, 16'h0);
    end
    out_credit_ret = 1'b0;
    #1;
    check("t2_rr_wrap", dut.rr_ptr_q, 0);
    check("t2_credit", dut.credit_q, 4);
    check("t2_err", {err_protocol, err_credit_ovf}, 0);

    // 3: credit exhaustion on a 6-flit packet from req2
    do_reset();
    for (int n = 0; n < 4; n++) begin
      put(2, 1, n == 0, 0, 16'(16'h30 + n));
      expect_xfer($sformatf("t3_flit%0d", n), 4'b0100, 16'(16'h30 + n));
      tick();
    end
    put(2, 1, 0, 0, 16'h34);
    expect_stall("t3_stall_a");
    check("t3_vcready0", req_VCready, 4'h0);
    tick();
    expect_stall("t3_stall_b");
    out_credit_ret = 1'b1;
    tick();
    out_credit_ret = 1'b0;
    expect_xfer("t3_one_more", 4'b0100, 16'h34);
    tick();
    put(2, 1, 0, 1, 16'h35);
    expect_stall("t3_stall_c");
    out_credit_ret = 1'b1;
    tick();
    expect_xfer("t3_tail", 4'b0100, 16'h35);
    tick();
    out_credit_ret = 1'b0;
    idle_all();
    #1;
    check("t3_same_cycle", dut.credit_q, 1);
    check("t3_idle", dut.state_q, StIdle);

    // 4: req1 holds the grant through bubbles while req2 waits
    do_reset();
    put(1, 1, 1, 0, 16'h41);
    expect_xfer("t4_head", 4'b0010, 16'h41);
    tick();
    put(1, 0, 0, 0, 16'h0);
    put(2, 1, 1, 1, 16'h52);
    for (int c = 0; c < 3; c++) begin
      expect_stall($sformatf("t4_bubble%0d", c));
      tick();
    end
    put(1, 1, 0, 0, 16'h42);
    expect_xfer("t4_body", 4'b0010, 16'h42);
    tick();
    put(1, 1, 0, 1, 16'h43);
    expect_xfer("t4_tail", 4'b0010, 16'h43);
    tick();
    put(1, 0, 0, 0, 16'h0);
    expect_xfer("t4_req2", 4'b0100, 16'h52);
    tick();
    idle_all();
    #1;
    check("t4_err", err_protocol, 0);

    // 5: single-flit packets from req0 and req3 alternate every cycle
    do_reset();
    put(0, 1, 1, 1, 16'h60);
    put(3, 1, 1, 1, 16'h63);
    out_credit_ret = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) expect_xfer($sformatf("t5_c%0d", c), 4'b0001, 16'h60);
      else            expect_xfer($sformatf("t5_c%0d", c), 4'b1000, 16'h63);
      tick();
      check($sformatf("t5_state%0d", c), dut.state_q, StIdle);
    end
    out_credit_ret = 1'b0;
    idle_all();

    // 6: reset mid-packet, then protocol and credit-overflow errors
    do_reset();
    put(0, 1, 1, 0, 16'h70);
    expect_xfer("t6_head", 4'b0001, 16'h70);
    tick();
    put(0, 1, 0, 0, 16'h71);
    rst = 1'b1;
    expect_stall("t6_rst_gate");
    tick();
    rst = 1'b0;
    idle_all();
    #1;
    check("t6_idle", dut.state_q, StIdle);
    check("t6_credit", dut.credit_q, 4);
    put(1, 1, 0, 0, 16'h81);
    expect_stall("t6_body_idle");
    check("t6_err_pre", err_protocol, 0);
    tick();
    idle_all();
    check("t6_err_proto", err_protocol, 1);
    out_credit_ret = 1'b1;
    tick();
    out_credit_ret = 1'b0;
    #1;
    check("t6_err_ovf", err_credit_ovf, 1);
    check("t6_credit_sat", dut.credit_q, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
